// File: rtl/io_putc_arbiter_pkg.sv
// Shared types and defaults for the dev_io putc arbiter.
package io_pkg;
  localparam int DEF_CHAR_W = 8;
  localparam int DEF_N_REQ  = 4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    BUBBLE
  } state_t;
endpackage

// File: rtl/io_putc_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of req searching upward
// from ptr+1, wrapping N-1 -> 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  // NOTE: every output gets a default before the loop so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = 1; k <= N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/io_putc_arbiter.sv
// Round-robin arbiter with string lock that shares the single dev_io putc
// port between N_REQ character producers.
module io_putc_arbiter
  import io_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int CHAR_W = DEF_CHAR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_lock,
  input  logic [N_REQ*CHAR_W-1:0] req_char,
  output logic [N_REQ-1:0]        req_ack,
  output logic [N_REQ-1:0]        grant,
  input  logic                    outbuf_full,
  output logic                    putc_push,
  output logic [CHAR_W-1:0]       putc_char
);

  localparam int IW = $clog2(N_REQ);

  state_t            state, state_n;
  logic [IW-1:0]     owner, owner_n;
  logic [IW-1:0]     ptr, ptr_n;
  logic [N_REQ-1:0]  grant_n;
  logic              push_n;
  logic [CHAR_W-1:0] char_n;

  logic [N_REQ-1:0]  pick_onehot;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;

  logic              owner_valid;
  logic              owner_lock;
  logic [CHAR_W-1:0] owner_char;
  logic              accept;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req    (req_valid),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    owner_char = '0;
    for (int i = 0; i < N_REQ; i++)
      if (owner == IW'(i)) owner_char = req_char[i*CHAR_W +: CHAR_W];
  end

  assign owner_valid = req_valid[owner];
  assign owner_lock  = req_lock[owner];
  assign accept      = (state == GRANT) && owner_valid && !outbuf_full;
  // grant is the owner's one-hot, so the ack can never reach a non-owner.
  assign req_ack     = accept ? grant : '0;

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    grant_n = grant;
    push_n  = 1'b0;
    char_n  = putc_char;
    case (state)
      IDLE: begin
        if (pick_any) begin
          owner_n = pick_idx;
          grant_n = pick_onehot;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          push_n  = 1'b1;
          char_n  = owner_char;
          state_n = BUBBLE;
        end else if (!owner_valid && !owner_lock) begin
          grant_n = '0;
          ptr_n   = owner;
          state_n = IDLE;
        end
      end
      BUBBLE: begin
        // One dead cycle so outbuf_full reflects the char just pushed.
        if (owner_lock) begin
          state_n = GRANT;
        end else begin
          grant_n = '0;
          ptr_n   = owner;
          state_n = IDLE;
        end
      end
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= IW'(N_REQ - 1);
      grant     <= '0;
      putc_push <= 1'b0;
      putc_char <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      ptr       <= ptr_n;
      grant     <= grant_n;
      putc_push <= push_n;
      putc_char <= char_n;
    end
  end

endmodule
